// File: rtl/alu_pkg.sv
// Shared types and constants for the ID/EX ALU operand stage.
package alu_pkg;

    localparam int unsigned DATA_WIDTH    = 32;
    localparam int unsigned OPCODE_LENGTH = 4;
    localparam int unsigned REG_IDX_W     = 5;

    localparam logic [OPCODE_LENGTH-1:0] ALU_AND  = 4'b0000;
    localparam logic [OPCODE_LENGTH-1:0] ALU_XOR  = 4'b0001;
    localparam logic [OPCODE_LENGTH-1:0] ALU_ADD  = 4'b0010;
    localparam logic [OPCODE_LENGTH-1:0] ALU_OR   = 4'b0011;
    localparam logic [OPCODE_LENGTH-1:0] ALU_SUB  = 4'b0100;
    localparam logic [OPCODE_LENGTH-1:0] ALU_ADDI = 4'b0101;
    localparam logic [OPCODE_LENGTH-1:0] ALU_EQ   = 4'b1000;

    typedef enum logic [1:0] {
        FWD_NONE = 2'd0,
        FWD_MEM  = 2'd1,
        FWD_WB   = 2'd2
    } fwd_sel_e;

    // Decoded instruction fields held in the ID/EX register
    typedef struct packed {
        logic [DATA_WIDTH-1:0]    rs1_data;
        logic [DATA_WIDTH-1:0]    rs2_data;
        logic [DATA_WIDTH-1:0]    imm;
        logic [DATA_WIDTH-1:0]    pc;
        logic [REG_IDX_W-1:0]     rs1;
        logic [REG_IDX_W-1:0]     rs2;
        logic [REG_IDX_W-1:0]     rd;
        logic                     alusrc_a;
        logic                     alusrc_b;
        logic [OPCODE_LENGTH-1:0] operation;
        logic                     regwrite;
        logic                     memread;
    } idex_t;

endpackage

// File: rtl/alu_operand_stage_if.sv
// Decoder-side, forwarding-side and ALU-side signals of the operand stage.
interface alu_operand_stage_if;
    import alu_pkg::*;

    logic                     in_valid;
    logic                     in_ready;
    logic [DATA_WIDTH-1:0]    id_rs1_data;
    logic [DATA_WIDTH-1:0]    id_rs2_data;
    logic [DATA_WIDTH-1:0]    id_imm;
    logic [DATA_WIDTH-1:0]    id_pc;
    logic [REG_IDX_W-1:0]     id_rs1;
    logic [REG_IDX_W-1:0]     id_rs2;
    logic [REG_IDX_W-1:0]     id_rd;
    logic                     id_alusrc_a;
    logic                     id_alusrc_b;
    logic [OPCODE_LENGTH-1:0] id_operation;
    logic                     id_regwrite;
    logic                     id_memread;
    logic                     flush;
    logic [REG_IDX_W-1:0]     mem_rd;
    logic                     mem_regwrite;
    logic                     mem_memread;
    logic [DATA_WIDTH-1:0]    mem_result;
    logic [REG_IDX_W-1:0]     wb_rd;
    logic                     wb_regwrite;
    logic [DATA_WIDTH-1:0]    wb_result;
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_WIDTH-1:0]    SrcA;
    logic [DATA_WIDTH-1:0]    SrcB;
    logic [OPCODE_LENGTH-1:0] Operation;
    logic [DATA_WIDTH-1:0]    ex_store_data;
    logic [REG_IDX_W-1:0]     ex_rd;
    logic                     ex_regwrite;
    logic                     ex_memread;

    modport master (
        output in_valid, id_rs1_data, id_rs2_data, id_imm, id_pc, id_rs1, id_rs2, id_rd,
               id_alusrc_a, id_alusrc_b, id_operation, id_regwrite, id_memread, flush,
               mem_rd, mem_regwrite, mem_memread, mem_result, wb_rd, wb_regwrite, wb_result,
               out_ready,
        input  in_ready, out_valid, SrcA, SrcB, Operation, ex_store_data, ex_rd,
               ex_regwrite, ex_memread
    );

    modport slave (
        input  in_valid, id_rs1_data, id_rs2_data, id_imm, id_pc, id_rs1, id_rs2, id_rd,
               id_alusrc_a, id_alusrc_b, id_operation, id_regwrite, id_memread, flush,
               mem_rd, mem_regwrite, mem_memread, mem_result, wb_rd, wb_regwrite, wb_result,
               out_ready,
        output in_ready, out_valid, SrcA, SrcB, Operation, ex_store_data, ex_rd,
               ex_regwrite, ex_memread
    );

endinterface

// File: rtl/alu_operand_stage_fwd_unit.sv
// Register-index compare for RAW forwarding and load-use detection.
module alu_operand_stage_fwd_unit
    import alu_pkg::*;
(
    input  logic                 i_valid,
    input  logic [REG_IDX_W-1:0] i_rs1,
    input  logic [REG_IDX_W-1:0] i_rs2,
    input  logic                 i_use_rs1,
    input  logic                 i_use_rs2,
    input  logic [REG_IDX_W-1:0] i_mem_rd,
    input  logic                 i_mem_regwrite,
    input  logic                 i_mem_memread,
    input  logic [REG_IDX_W-1:0] i_wb_rd,
    input  logic                 i_wb_regwrite,
    output fwd_sel_e             o_sel_a_c,
    output fwd_sel_e             o_sel_b_c,
    output logic                 o_load_use_c
);

    logic w_mem_fwd;
    logic w_mem_load;

    assign w_mem_fwd  = i_mem_regwrite && !i_mem_memread;
    assign w_mem_load = i_mem_regwrite && i_mem_memread && (i_mem_rd != '0);

    // Source selects: MEM over WB over register-file data; x0 never forwards
    always_comb begin
        o_sel_a_c = FWD_NONE;
        o_sel_b_c = FWD_NONE;
        if (i_rs1 != '0) begin
            if (w_mem_fwd && (i_mem_rd == i_rs1))         o_sel_a_c = FWD_MEM;
            else if (i_wb_regwrite && (i_wb_rd == i_rs1)) o_sel_a_c = FWD_WB;
        end
        if (i_rs2 != '0) begin
            if (w_mem_fwd && (i_mem_rd == i_rs2))         o_sel_b_c = FWD_MEM;
            else if (i_wb_regwrite && (i_wb_rd == i_rs2)) o_sel_b_c = FWD_WB;
        end
    end

    // Load in MEM whose destination a used source of the held instruction needs
    always_comb begin
        o_load_use_c = 1'b0;
        if (i_valid && w_mem_load) begin
            o_load_use_c = (i_use_rs1 && (i_mem_rd == i_rs1)) ||
                           (i_use_rs2 && (i_mem_rd == i_rs2));
        end
    end

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX register feeding the ALU with operand muxing.
// Optional feature macro ALU_FWD_EN: forwarding from MEM/WB and load-use stall.
module alu_operand_stage
    import alu_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    alu_operand_stage_if.slave  bus
);

    logic                  r_valid;
    idex_t                 r_idex;
    idex_t                 w_idex_d;
    logic                  w_capture;
    logic                  w_consume;
    logic                  w_out_valid;
    logic                  w_hazard;
    logic [DATA_WIDTH-1:0] w_fwd_a;
    logic [DATA_WIDTH-1:0] w_fwd_b;

    assign w_idex_d = '{
        rs1_data:  bus.id_rs1_data,
        rs2_data:  bus.id_rs2_data,
        imm:       bus.id_imm,
        pc:        bus.id_pc,
        rs1:       bus.id_rs1,
        rs2:       bus.id_rs2,
        rd:        bus.id_rd,
        alusrc_a:  bus.id_alusrc_a,
        alusrc_b:  bus.id_alusrc_b,
        operation: bus.id_operation,
        regwrite:  bus.id_regwrite,
        memread:   bus.id_memread
    };

`ifdef ALU_FWD_EN
    fwd_sel_e w_sel_a;
    fwd_sel_e w_sel_b;
    logic     w_is_store;

    // A store has an immediate SrcB but still needs rs2 as its data
    assign w_is_store = r_idex.alusrc_b && !r_idex.regwrite && !r_idex.memread;

    alu_operand_stage_fwd_unit u_fwd_unit (
        .i_valid        (r_valid),
        .i_rs1          (r_idex.rs1),
        .i_rs2          (r_idex.rs2),
        .i_use_rs1      (!r_idex.alusrc_a),
        .i_use_rs2      (!r_idex.alusrc_b || w_is_store),
        .i_mem_rd       (bus.mem_rd),
        .i_mem_regwrite (bus.mem_regwrite),
        .i_mem_memread  (bus.mem_memread),
        .i_wb_rd        (bus.wb_rd),
        .i_wb_regwrite  (bus.wb_regwrite),
        .o_sel_a_c      (w_sel_a),
        .o_sel_b_c      (w_sel_b),
        .o_load_use_c   (w_hazard)
    );

    // Forwarding data muxes, re-evaluated every cycle the instruction is held
    always_comb begin
        w_fwd_a = r_idex.rs1_data;
        w_fwd_b = r_idex.rs2_data;
        case (w_sel_a)
            FWD_MEM: w_fwd_a = bus.mem_result;
            FWD_WB:  w_fwd_a = bus.wb_result;
            default: w_fwd_a = r_idex.rs1_data;
        endcase
        case (w_sel_b)
            FWD_MEM: w_fwd_b = bus.mem_result;
            FWD_WB:  w_fwd_b = bus.wb_result;
            default: w_fwd_b = r_idex.rs2_data;
        endcase
    end
`else
    logic w_unused_fwd;

    // No forwarding: upstream schedules NOPs, so register data is always current
    assign w_hazard     = 1'b0;
    assign w_fwd_a      = r_idex.rs1_data;
    assign w_fwd_b      = r_idex.rs2_data;
    assign w_unused_fwd = ^{bus.mem_rd, bus.mem_regwrite, bus.mem_memread, bus.mem_result,
                            bus.wb_rd, bus.wb_regwrite, bus.wb_result, r_idex.rs1, r_idex.rs2};
`endif

    assign w_out_valid = r_valid && !w_hazard;
    assign w_consume   = w_out_valid && bus.out_ready;
    assign bus.in_ready = !r_valid || w_consume;
    assign w_capture   = bus.in_valid && bus.in_ready;

    // Valid bit and instruction fields; flush wins over a same-cycle capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_idex  <= '0;
        end else begin
            if (bus.flush)      r_valid <= 1'b0;
            else if (w_capture) r_valid <= 1'b1;
            else if (w_consume) r_valid <= 1'b0;
            if (w_capture && !bus.flush) r_idex <= w_idex_d;
        end
    end

    // Operand selection and pass-through fields straight from the held register
    assign bus.out_valid     = w_out_valid;
    assign bus.SrcA          = r_idex.alusrc_a ? r_idex.pc  : w_fwd_a;
    assign bus.SrcB          = r_idex.alusrc_b ? r_idex.imm : w_fwd_b;
    assign bus.ex_store_data = w_fwd_b;
    assign bus.Operation     = r_idex.operation;
    assign bus.ex_rd         = r_idex.rd;
    assign bus.ex_regwrite   = r_idex.regwrite;
    assign bus.ex_memread    = r_idex.memread;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed scoreboard bench for alu_operand_stage (either ALU_FWD_EN setting).
module tb_alu_operand_stage;
    import alu_pkg::*;

`ifdef ALU_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] srca;
        logic [31:0] srcb;
        logic [3:0]  op;
        logic [31:0] store;
    } sb_item_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    sb_item_t sb_q[$];

    alu_operand_stage_if bus ();

    alu_operand_stage u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic sb_push(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                           input logic [31:0] st);
        sb_item_t it;
        it.srca  = a;
        it.srcb  = b;
        it.op    = op;
        it.store = st;
        sb_q.push_back(it);
    endtask

    // Compare the instruction the ALU is accepting against the oldest expectation
    task automatic sb_pop();
        sb_item_t it;
        n_checks++;
        assert (sb_q.size() != 0)
        else begin
            n_fail++;
            $error("FAIL sb_underflow observed=output expected=none");
        end
        if (sb_q.size() != 0) begin
            it = sb_q.pop_front();
            check("sb_srca",  bus.SrcA, it.srca);
            check("sb_srcb",  bus.SrcB, it.srcb);
            check("sb_op",    32'(bus.Operation), 32'(it.op));
            check("sb_store", bus.ex_store_data, it.store);
        end
    endtask

    // Let combinational outputs settle, then consume if the ALU takes an instruction
    task automatic settle();
        #1;
        if (bus.out_valid && bus.out_ready) sb_pop();
    endtask

    task automatic drive(input logic [4:0] rs1, input logic [31:0] d1,
                         input logic [4:0] rs2, input logic [31:0] d2,
                         input logic [4:0] rd, input logic asrc, input logic bsrc,
                         input logic [31:0] pc, input logic [31:0] imm, input logic [3:0] op);
        bus.in_valid     = 1'b1;
        bus.id_rs1       = rs1;
        bus.id_rs1_data  = d1;
        bus.id_rs2       = rs2;
        bus.id_rs2_data  = d2;
        bus.id_rd        = rd;
        bus.id_alusrc_a  = asrc;
        bus.id_alusrc_b  = bsrc;
        bus.id_pc        = pc;
        bus.id_imm       = imm;
        bus.id_operation = op;
        bus.id_regwrite  = 1'b1;
        bus.id_memread   = 1'b0;
    endtask

    task automatic set_mem(input logic [4:0] rd, input logic rw, input logic mr, input logic [31:0] res);
        bus.mem_rd       = rd;
        bus.mem_regwrite = rw;
        bus.mem_memread  = mr;
        bus.mem_result   = res;
    endtask

    task automatic set_wb(input logic [4:0] rd, input logic rw, input logic [31:0] res);
        bus.wb_rd       = rd;
        bus.wb_regwrite = rw;
        bus.wb_result   = res;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        bus.out_ready = 1'b1;
        drive(5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        bus.in_valid    = 1'b0;
        bus.id_regwrite = 1'b0;
        set_mem(5'd0, 1'b0, 1'b0, 32'd0);
        set_wb(5'd0, 1'b0, 32'd0);

        // Reset state
        #1;
        check("rst_out_valid",   32'(bus.out_valid), 32'd0);
        check("rst_in_ready",    32'(bus.in_ready), 32'd1);
        check("rst_srca",        bus.SrcA, 32'd0);
        check("rst_srcb",        bus.SrcB, 32'd0);
        check("rst_op",          32'(bus.Operation), 32'd0);
        check("rst_store",       bus.ex_store_data, 32'd0);
        check("rst_ex_rd",       32'(bus.ex_rd), 32'd0);
        check("rst_ex_regwrite", 32'(bus.ex_regwrite), 32'd0);
        check("rst_ex_memread",  32'(bus.ex_memread), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Plain ADD, one-cycle latency
        @(negedge clk);
        drive(5'd5, 32'd7, 5'd6, 32'd3, 5'd7, 1'b0, 1'b0, 32'h0, 32'h0, ALU_ADD);
        settle();
        check("t1_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        sb_push(32'd7, 32'd3, ALU_ADD, 32'd3);
        settle();
        check("t1_out_valid", 32'(bus.out_valid), 32'd1);
        check("t1_ex_rd",     32'(bus.ex_rd), 32'd7);
        check("t1_ex_rw",     32'(bus.ex_regwrite), 32'd1);

        // MEM beats WB; WB used once MEM no longer matches
        @(negedge clk);
        bus.out_ready = 1'b0;
        drive(5'd5, 32'h1, 5'd6, 32'h2, 5'd8, 1'b0, 1'b0, 32'h0, 32'h0, ALU_ADD);
        set_mem(5'd5, 1'b1, 1'b0, 32'h10);
        set_wb(5'd5, 1'b1, 32'h20);
        settle();
        @(negedge clk);
        bus.in_valid = 1'b0;
        settle();
        check("t2_mem_wins", bus.SrcA, FWD ? 32'h10 : 32'h1);
        @(negedge clk);
        bus.mem_regwrite = 1'b0;
        settle();
        check("t2_wb_fwd", bus.SrcA, FWD ? 32'h20 : 32'h1);
        @(negedge clk);
        set_wb(5'd0, 1'b0, 32'h0);
        bus.out_ready = 1'b1;
        sb_push(32'h1, 32'h2, ALU_ADD, 32'h2);
        settle();

        // Load-use on rs2, then WB supplies the loaded value
        @(negedge clk);
        set_mem(5'd0, 1'b0, 1'b0, 32'h0);
        drive(5'd1, 32'h11, 5'd6, 32'h22, 5'd9, 1'b0, 1'b0, 32'h0, 32'h0, ALU_SUB);
        settle();
        @(negedge clk);
        bus.in_valid = 1'b0;
        set_mem(5'd6, 1'b1, 1'b1, 32'hDEAD);
        if (!FWD) sb_push(32'h11, 32'h22, ALU_SUB, 32'h22);
        settle();
        check("t3_stall_out_valid", 32'(bus.out_valid), FWD ? 32'd0 : 32'd1);
        check("t3_stall_in_ready",  32'(bus.in_ready),  FWD ? 32'd0 : 32'd1);
        @(negedge clk);
        set_mem(5'd0, 1'b0, 1'b0, 32'h0);
        set_wb(5'd6, 1'b1, 32'h55);
        if (FWD) sb_push(32'h11, 32'h55, ALU_SUB, 32'h55);
        settle();
        check("t3_after_out_valid", 32'(bus.out_valid), FWD ? 32'd1 : 32'd0);

        // Backpressure for 3 cycles, then same-edge replace
        @(negedge clk);
        set_wb(5'd0, 1'b0, 32'h0);
        bus.out_ready = 1'b0;
        drive(5'd2, 32'hA0, 5'd3, 32'hB0, 5'd10, 1'b1, 1'b1, 32'h100, 32'h4, ALU_ADDI);
        settle();
        check("t4_first_in_ready", 32'(bus.in_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(5'd2, 32'hC0, 5'd3, 32'hD0, 5'd11, 1'b0, 1'b0, 32'h0, 32'h0, ALU_XOR);
            settle();
            check("t4_bp_in_ready", 32'(bus.in_ready), 32'd0);
            check("t4_bp_srca",     bus.SrcA, 32'h100);
            check("t4_bp_srcb",     bus.SrcB, 32'h4);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        sb_push(32'h100, 32'h4, ALU_ADDI, 32'hB0);
        settle();
        check("t4_release_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        sb_push(32'hC0, 32'hD0, ALU_XOR, 32'hD0);
        settle();

        // Flush drops a simultaneous capture
        @(negedge clk);
        drive(5'd7, 32'h99, 5'd8, 32'h98, 5'd14, 1'b0, 1'b0, 32'h0, 32'h0, ALU_EQ);
        bus.flush = 1'b1;
        settle();
        check("t5_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        settle();
        check("t5_flush_out_valid", 32'(bus.out_valid), 32'd0);

        // Register x0 never forwards
        @(negedge clk);
        drive(5'd0, 32'h0, 5'd0, 32'h0, 5'd12, 1'b0, 1'b0, 32'h0, 32'h0, ALU_OR);
        set_mem(5'd0, 1'b1, 1'b0, 32'hFF);
        set_wb(5'd0, 1'b1, 32'hFF);
        settle();
        @(negedge clk);
        bus.in_valid = 1'b0;
        sb_push(32'h0, 32'h0, ALU_OR, 32'h0);
        settle();

        // Asynchronous reset while held
        @(negedge clk);
        set_mem(5'd0, 1'b0, 1'b0, 32'h0);
        set_wb(5'd0, 1'b0, 32'h0);
        bus.out_ready = 1'b0;
        drive(5'd4, 32'h77, 5'd5, 32'h1, 5'd13, 1'b0, 1'b0, 32'h0, 32'h0, ALU_AND);
        settle();
        @(negedge clk);
        bus.in_valid = 1'b0;
        set_mem(5'd4, 1'b1, 1'b1, 32'h0);
        settle();
        check("t6_held_srca",      bus.SrcA, 32'h77);
        check("t6_held_out_valid", 32'(bus.out_valid), FWD ? 32'd0 : 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_arst_out_valid", 32'(bus.out_valid), 32'd0);
        check("t6_arst_srca",      bus.SrcA, 32'd0);
        check("t6_arst_ex_rd",     32'(bus.ex_rd), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        set_mem(5'd0, 1'b0, 1'b0, 32'h0);
        bus.out_ready = 1'b1;
        settle();
        check("t6_restart_out_valid", 32'(bus.out_valid), 32'd0);
        check("t6_restart_in_ready",  32'(bus.in_ready), 32'd1);

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
